// File: rtl/ad7960_emulator.sv
// AD7960 ADC emulator: a CNV rising edge latches a value from a selectable pattern
// generator, then the value is shifted out MSB first, gated by the controller's SCLK enable.
module ad7960_emulator #(
    parameter logic [8:0]  TCONV_CNT = 9'd30,
    parameter logic [17:0] RAMP_STEP = 18'd1,
    parameter logic [17:0] LFSR_SEED = 18'h2AAAA
) (
    input  logic        fast_clk_i,
    input  logic        buffer_reset_s,
    input  logic        cnv_i,
    input  logic        sclk_en_i,
    input  logic [1:0]  mode_i,
    input  logic [17:0] const_i,
    output logic        d_o,
    output logic        dco_o,
    output logic        busy_o,
    output logic [17:0] sample_o,
    output logic [15:0] sample_cnt_o,
    output logic        cnv_err_o,
    output logic        lost_o,
    output logic        early_clk_o
);
    localparam logic [17:0] ALT_START = 18'h2AAAA;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_CONVERT = 4'b0010,
        ST_READY   = 4'b0100,
        ST_SHIFT   = 4'b1000
    } state_e;

    typedef enum logic [1:0] {
        MODE_CONST = 2'b00,
        MODE_RAMP  = 2'b01,
        MODE_PRBS  = 2'b10,
        MODE_ALT   = 2'b11
    } mode_e;

    state_e      state_q, state_d;
    logic        cnv_q, cnv_qq;
    logic [8:0]  tconv_q, tconv_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [17:0] shift_q, shift_d;
    logic [17:0] sample_q, sample_d;
    logic [15:0] sample_cnt_q, sample_cnt_d;
    logic [17:0] ramp_q, ramp_d;
    logic [17:0] lfsr_q, lfsr_d;
    logic [17:0] alt_q, alt_d;
    logic        d_q, d_d;
    logic        dco_en_q, dco_en_d;
    logic        cnv_err_q, cnv_err_d;
    logic        lost_q, lost_d;
    logic        early_clk_q, early_clk_d;
    logic        cnv_edge, start, last_bit;
    logic [17:0] pattern;

    assign cnv_edge = cnv_q & ~cnv_qq;

    always_comb begin
        unique case (mode_e'(mode_i))
            MODE_CONST: pattern = const_i;
            MODE_RAMP:  pattern = ramp_q;
            MODE_PRBS:  pattern = lfsr_q;
            default:    pattern = alt_q;
        endcase
    end

    // NOTE: every signal written here is given a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        tconv_d      = tconv_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        sample_d     = sample_q;
        sample_cnt_d = sample_cnt_q;
        ramp_d       = ramp_q;
        lfsr_d       = lfsr_q;
        alt_d        = alt_q;
        d_d          = 1'b0;
        dco_en_d     = 1'b0;
        cnv_err_d    = 1'b0;
        lost_d       = 1'b0;
        early_clk_d  = 1'b0;
        start        = 1'b0;
        last_bit     = 1'b0;

        unique case (state_q)
            ST_IDLE: start = cnv_edge;
            ST_CONVERT: begin
                cnv_err_d   = cnv_edge;
                early_clk_d = sclk_en_i;
                tconv_d     = tconv_q - 9'd1;
                if (tconv_q <= 9'd1) begin
                    state_d = ST_READY;
                    shift_d = sample_q;
                    d_d     = sample_q[17];
                end
            end
            ST_READY: begin
                if (cnv_edge) begin
                    lost_d = 1'b1;
                    start  = 1'b1;
                end else begin
                    // d_o trails shift_q[17] by a cycle so it holds still under each dco pulse.
                    d_d = shift_q[17];
                    if (sclk_en_i) begin
                        state_d   = ST_SHIFT;
                        bit_cnt_d = 5'd17;
                        dco_en_d  = 1'b1;
                        shift_d   = {shift_q[16:0], 1'b0};
                    end
                end
            end
            ST_SHIFT: begin
                last_bit = sclk_en_i && (bit_cnt_q == 5'd1);
                if (cnv_edge && !last_bit) begin
                    lost_d = 1'b1;
                    start  = 1'b1;
                end else begin
                    d_d = shift_q[17];
                    if (sclk_en_i) begin
                        dco_en_d  = 1'b1;
                        shift_d   = {shift_q[16:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        if (last_bit) state_d = ST_IDLE;
                        start = cnv_edge;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Only the selected generator advances; the others keep their state across mode changes.
        if (start) begin
            state_d      = ST_CONVERT;
            tconv_d      = TCONV_CNT;
            sample_d     = pattern;
            sample_cnt_d = sample_cnt_q + 16'd1;
            unique case (mode_e'(mode_i))
                MODE_RAMP: ramp_d = ramp_q + RAMP_STEP;
                MODE_PRBS: lfsr_d = {lfsr_q[16:0], lfsr_q[17] ^ lfsr_q[10]};
                MODE_ALT:  alt_d  = ~alt_q;
                default:   ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge fast_clk_i or posedge buffer_reset_s) begin
        if (buffer_reset_s) begin
            state_q      <= ST_IDLE;
            cnv_q        <= 1'b0;
            cnv_qq       <= 1'b0;
            tconv_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            sample_q     <= '0;
            sample_cnt_q <= '0;
            ramp_q       <= '0;
            lfsr_q       <= LFSR_SEED;
            alt_q        <= ALT_START;
            d_q          <= 1'b0;
            dco_en_q     <= 1'b0;
            cnv_err_q    <= 1'b0;
            lost_q       <= 1'b0;
            early_clk_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnv_q        <= cnv_i;
            cnv_qq       <= cnv_q;
            tconv_q      <= tconv_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            sample_q     <= sample_d;
            sample_cnt_q <= sample_cnt_d;
            ramp_q       <= ramp_d;
            lfsr_q       <= lfsr_d;
            alt_q        <= alt_d;
            d_q          <= d_d;
            dco_en_q     <= dco_en_d;
            cnv_err_q    <= cnv_err_d;
            lost_q       <= lost_d;
            early_clk_q  <= early_clk_d;
        end
    end

    assign d_o          = d_q;
    assign dco_o        = ~fast_clk_i & dco_en_q;
    assign busy_o       = (state_q == ST_CONVERT);
    assign sample_o     = sample_q;
    assign sample_cnt_o = sample_cnt_q;
    assign cnv_err_o    = cnv_err_q;
    assign lost_o       = lost_q;
    assign early_clk_o  = early_clk_q;

endmodule
